// File: rtl/booth_mul_seq_r4.sv
// Iterative radix-4 Booth multiplier for unsigned mantissas: one partial product
// per clock into a carry-corrected accumulator, valid/ready on both sides.
module booth_mul_seq_r4 #(
    parameter int unsigned DWIDTH = 11
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DWIDTH-1:0]     in_a,
    input  logic [DWIDTH-1:0]     in_b,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [2*DWIDTH-1:0]   out_p
);

    localparam int unsigned NPP = DWIDTH / 2 + 1;
    localparam int unsigned PW  = 2 * DWIDTH;
    localparam int unsigned AW  = PW + 2;
    localparam int unsigned BW  = DWIDTH + 3;
    localparam int unsigned CW  = (NPP > 1) ? $clog2(NPP) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t              state_q;
    state_t              state_nx;
    logic                in_ready_q;
    logic                out_valid_q;
    logic [DWIDTH-1:0]   a_q;
    logic [BW-1:0]       b_q;
    logic [AW-1:0]       acc_q;
    logic [CW-1:0]       cnt_q;

    logic [AW-1:0]       pp;
    logic                pp_neg;
    logic [AW-1:0]       pp_sh;
    logic [AW-1:0]       carry_sh;

    // Booth digit from B[2:0]; negative digits use one's complement plus carry-in
    always_comb begin
        pp     = '0;
        pp_neg = 1'b0;
        case (b_q[2:0])
            3'b001, 3'b010: pp = AW'(a_q);
            3'b011:         pp = AW'({a_q, 1'b0});
            3'b100: begin
                pp     = ~AW'({a_q, 1'b0});
                pp_neg = 1'b1;
            end
            3'b101, 3'b110: begin
                pp     = ~AW'(a_q);
                pp_neg = 1'b1;
            end
            default: pp = '0;
        endcase
        pp_sh    = pp << {cnt_q, 1'b0};
        carry_sh = AW'(pp_neg) << {cnt_q, 1'b0};
    end

    // Next-state logic
    always_comb begin
        state_nx = state_q;
        case (state_q)
            IDLE: if (in_valid) state_nx = BUSY;
            BUSY: if (cnt_q == CW'(NPP - 1)) state_nx = DONE;
            DONE: if (out_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // State register; handshake flags are registered decodes of the next state
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_nx;
            in_ready_q  <= (state_nx == IDLE);
            out_valid_q <= (state_nx == DONE);
        end
    end

    // Operand capture and digit-serial accumulation
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_q   <= '0;
            b_q   <= '0;
            acc_q <= '0;
            cnt_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        a_q   <= in_a;
                        b_q   <= {2'b00, in_b, 1'b0};
                        acc_q <= '0;
                        cnt_q <= '0;
                    end
                end
                BUSY: begin
                    acc_q <= acc_q + pp_sh + carry_sh;
                    b_q   <= b_q >> 2;
                    cnt_q <= cnt_q + CW'(1);
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_p     = acc_q[PW-1:0];

endmodule

// File: tb/tb_booth_mul_seq_r4.sv
// Self-checking bench for booth_mul_seq_r4 at DWIDTH=11 and DWIDTH=24 against
// a plain integer-multiply reference.
module tb_booth_mul_seq_r4;

    logic        clk = 1'b0;
    logic        rst_n;

    logic        in_valid, in_ready, out_valid, out_ready;
    logic [10:0] in_a, in_b;
    logic [21:0] out_p;

    logic        in_valid24, in_ready24, out_valid24, out_ready24;
    logic [23:0] in_a24, in_b24;
    logic [47:0] out_p24;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    booth_mul_seq_r4 #(.DWIDTH(11)) dut11 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
        .out_valid(out_valid), .out_ready(out_ready), .out_p(out_p)
    );

    booth_mul_seq_r4 #(.DWIDTH(24)) dut24 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid24), .in_ready(in_ready24), .in_a(in_a24), .in_b(in_b24),
        .out_valid(out_valid24), .out_ready(out_ready24), .out_p(out_p24)
    );

    typedef struct {
        logic [10:0] a;
        logic [10:0] b;
        logic [63:0] p;
    } vec_t;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One full transaction on the 11-bit instance with latency and handshake checks
    task automatic op11(input logic [10:0] a, input logic [10:0] b,
                        output logic [63:0] p, output int lat);
        int n = 0;
        while (!in_ready && n < 50) begin tick(); n++; end
        in_valid = 1'b1; in_a = a; in_b = b;
        tick();
        in_valid = 1'b0;
        in_a = 11'($urandom); in_b = 11'($urandom);
        chk("in_ready_low_after_accept", in_ready, 1'b0);
        lat = 0;
        while (!out_valid && lat < 100) begin tick(); lat++; end
        p = 64'(out_p);
        chk("acc_top_zero_11", 64'(dut11.acc_q[23:22]), 64'd0);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("out_valid_low_after_xfer", out_valid, 1'b0);
        chk("in_ready_high_after_xfer", in_ready, 1'b1);
    endtask

    task automatic rand11(input int nops);
        for (int k = 0; k < nops; k++) begin
            logic [10:0] a, b;
            logic [63:0] exp;
            int   n = 0;
            bit   seen = 0;
            bit   done = 0;
            a = (($urandom % 8) == 0) ? 11'h7FF : 11'($urandom);
            b = (($urandom % 8) == 0) ? 11'h000 : 11'($urandom);
            exp = 64'(a) * 64'(b);
            while (!in_ready && n < 50) begin tick(); n++; end
            in_valid = 1'b1; in_a = a; in_b = b;
            tick();
            in_valid = 1'b0; in_a = 11'($urandom); in_b = 11'($urandom);
            n = 0;
            while (!done && n < 200) begin
                out_ready = 1'($urandom_range(0, 1));
                if (out_valid) begin
                    if (!seen) begin
                        chk("rand11_acc_top", 64'(dut11.acc_q[23:22]), 64'd0);
                        seen = 1;
                    end
                    if (out_ready) begin
                        chk("rand11_p", 64'(out_p), exp);
                        done = 1;
                    end
                end
                tick();
                n++;
            end
            out_ready = 1'b0;
            if (!done) chk("rand11_timeout", 64'd0, 64'd1);
        end
    endtask

    task automatic rand24(input int nops);
        for (int k = 0; k < nops; k++) begin
            logic [23:0] a, b;
            logic [63:0] exp;
            int   n = 0;
            bit   seen = 0;
            bit   done = 0;
            a = (($urandom % 8) == 0) ? 24'hFFFFFF : 24'($urandom);
            b = (($urandom % 8) == 0) ? 24'hFFFFFF : 24'($urandom);
            exp = 64'(a) * 64'(b);
            while (!in_ready24 && n < 50) begin tick(); n++; end
            in_valid24 = 1'b1; in_a24 = a; in_b24 = b;
            tick();
            in_valid24 = 1'b0; in_a24 = 24'($urandom); in_b24 = 24'($urandom);
            n = 0;
            while (!done && n < 200) begin
                out_ready24 = 1'($urandom_range(0, 1));
                if (out_valid24) begin
                    if (!seen) begin
                        chk("rand24_acc_top", 64'(dut24.acc_q[49:48]), 64'd0);
                        seen = 1;
                    end
                    if (out_ready24) begin
                        chk("rand24_p", 64'(out_p24), exp);
                        done = 1;
                    end
                end
                tick();
                n++;
            end
            out_ready24 = 1'b0;
            if (!done) chk("rand24_timeout", 64'd0, 64'd1);
        end
    endtask

    initial begin
        vec_t        vecs[6];
        logic [63:0] p;
        int          lat;

        vecs[0] = '{a: 11'h7FF, b: 11'h7FF, p: 64'h3FF001};
        vecs[1] = '{a: 11'h400, b: 11'h400, p: 64'h100000};
        vecs[2] = '{a: 11'h001, b: 11'h555, p: 64'h000555};
        vecs[3] = '{a: 11'h000, b: 11'h7FF, p: 64'h000000};
        vecs[4] = '{a: 11'h7FF, b: 11'h001, p: 64'h0007FF};
        vecs[5] = '{a: 11'h555, b: 11'h2AA, p: 64'h0E3472};

        rst_n = 1'b0;
        in_valid = 1'b0; in_a = '0; in_b = '0; out_ready = 1'b0;
        in_valid24 = 1'b0; in_a24 = '0; in_b24 = '0; out_ready24 = 1'b0;
        tick(); tick();
        rst_n = 1'b1;
        chk("reset_in_ready", in_ready, 1'b1);
        chk("reset_out_valid", out_valid, 1'b0);
        chk("reset_out_p", 64'(out_p), 64'd0);

        // Directed vectors
        foreach (vecs[i]) begin
            op11(vecs[i].a, vecs[i].b, p, lat);
            chk($sformatf("vec%0d_p", i), p, vecs[i].p);
            chk($sformatf("vec%0d_latency", i), 64'(lat), 64'd6);
        end

        // Back-pressure: hold product while inputs toggle
        begin
            int n = 0;
            in_valid = 1'b1; in_a = 11'h123; in_b = 11'h456;
            tick();
            in_valid = 1'b0;
            while (!out_valid && n < 100) begin tick(); n++; end
            for (int c = 0; c < 5; c++) begin
                in_valid = 1'($urandom); in_a = 11'($urandom); in_b = 11'($urandom);
                tick();
                chk("bp_out_valid", out_valid, 1'b1);
                chk("bp_out_p", 64'(out_p), 64'h123 * 64'h456);
                chk("bp_in_ready", in_ready, 1'b0);
            end
            in_valid = 1'b0;
            out_ready = 1'b1;
            tick();
            out_ready = 1'b0;
            chk("bp_xfer_out_valid", out_valid, 1'b0);
            chk("bp_xfer_in_ready", in_ready, 1'b1);
        end

        // Reset in the middle of BUSY
        begin
            int stray = 0;
            in_valid = 1'b1; in_a = 11'h7FF; in_b = 11'h7FF;
            tick();
            in_valid = 1'b0;
            tick(); tick();
            rst_n = 1'b0;
            tick();
            rst_n = 1'b1;
            chk("midrst_in_ready", in_ready, 1'b1);
            chk("midrst_out_valid", out_valid, 1'b0);
            chk("midrst_out_p", 64'(out_p), 64'd0);
            for (int c = 0; c < 8; c++) begin
                if (out_valid) stray++;
                tick();
            end
            chk("midrst_no_stray_product", 64'(stray), 64'd0);
            op11(11'h003, 11'h005, p, lat);
            chk("midrst_next_p", p, 64'h00000F);
            chk("midrst_next_latency", 64'(lat), 64'd6);
        end

        // Back-to-back with in_valid and out_ready held high
        begin
            logic [63:0] q[$];
            int acc_cyc[4];
            int n_acc = 0;
            int got = 0;
            int cyc = 0;
            bit acc_now;
            in_a = 11'($urandom); in_b = 11'($urandom);
            in_valid = 1'b1; out_ready = 1'b1;
            while (got < 4 && cyc < 200) begin
                acc_now = in_valid && in_ready;
                if (acc_now) begin
                    q.push_back(64'(in_a) * 64'(in_b));
                    acc_cyc[n_acc] = cyc;
                    n_acc++;
                end
                if (out_valid && out_ready) begin
                    if (q.size() > 0) chk("b2b_p", 64'(out_p), q.pop_front());
                    else chk("b2b_unexpected_product", 64'd1, 64'd0);
                    got++;
                end
                tick();
                cyc++;
                if (acc_now) begin
                    if (n_acc == 4) in_valid = 1'b0;
                    else begin in_a = 11'($urandom); in_b = 11'($urandom); end
                end
            end
            in_valid = 1'b0; out_ready = 1'b0;
            chk("b2b_products", 64'(got), 64'd4);
            chk("b2b_accepts", 64'(n_acc), 64'd4);
            chk("b2b_queue_empty", 64'(q.size()), 64'd0);
            for (int i = 1; i < n_acc; i++)
                chk("b2b_spacing", 64'(acc_cyc[i] - acc_cyc[i-1]), 64'd8);
        end

        // Random operands with random back-pressure at both widths
        rand11(1500);
        rand24(800);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
